// File: rtl/cvxif_copro_pkg.sv
// Shared types for the CV-X-IF coprocessor responder: opcode, op encoding,
// FSM states and the queue-entry bookkeeping record.
`default_nettype none

package cvxif_copro_pkg;

    localparam logic [6:0] OPCODE_COPRO  = 7'b1111011;
    localparam logic [1:0] MUL_CNT_INIT  = 2'd3;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_XOR = 3'b001,
        OP_MUL = 3'b010,
        OP_NOP = 3'b011
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    typedef struct packed {
        op_e        op;
        logic [4:0] rd;
        logic       committed;
        logic       killed;
    } entry_meta_t;

endpackage

`default_nettype wire

// File: rtl/cvxif_copro_fifo.sv
// In-order instruction queue with per-entry commit/kill flag updates and
// exposed entry ids so the owner can match commits against stored entries.
`default_nettype none

module cvxif_copro_fifo
    import cvxif_copro_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int Depth   = 4,
    parameter int IdWidth = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            push_i,
    input  logic [IdWidth-1:0]              push_id_i,
    input  entry_meta_t                     push_meta_i,
    input  logic [XLEN-1:0]                 push_rs1_i,
    input  logic [XLEN-1:0]                 push_rs2_i,
    input  logic                            pop_i,
    input  logic [Depth-1:0]                commit_set_i,
    input  logic [Depth-1:0]                kill_set_i,
    output logic                            not_full_o,
    output logic                            head_valid_o,
    output logic [IdWidth-1:0]              head_id_o,
    output entry_meta_t                     head_meta_o,
    output logic [XLEN-1:0]                 head_rs1_o,
    output logic [XLEN-1:0]                 head_rs2_o,
    output logic [Depth-1:0]                entry_valid_o,
    output logic [Depth-1:0][IdWidth-1:0]   entry_ids_o
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;
    localparam logic [CntW-1:0] DEPTH_CNT = CntW'(Depth);

    logic [PtrW-1:0]    wr_ptr;
    logic [PtrW-1:0]    rd_ptr;
    logic [CntW-1:0]    count;
    logic [Depth-1:0]   valid;
    entry_meta_t        meta  [Depth];
    logic [IdWidth-1:0] ids   [Depth];
    logic [XLEN-1:0]    rs1   [Depth];
    logic [XLEN-1:0]    rs2   [Depth];

    // Payload arrays are not reset; the valid bits gate every use of them.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= '0;
        end else begin
            for (int i = 0; i < Depth; i++) begin
                if (valid[i] && kill_set_i[i]) begin
                    meta[i].killed <= 1'b1;
                end else if (valid[i] && commit_set_i[i]) begin
                    meta[i].committed <= 1'b1;
                end
            end
            if (push_i) begin
                meta[wr_ptr]  <= push_meta_i;
                ids[wr_ptr]   <= push_id_i;
                rs1[wr_ptr]   <= push_rs1_i;
                rs2[wr_ptr]   <= push_rs2_i;
                valid[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop_i) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign not_full_o   = (count < DEPTH_CNT);
    assign head_valid_o = valid[rd_ptr];
    assign head_id_o    = ids[rd_ptr];
    assign head_meta_o  = meta[rd_ptr];
    assign head_rs1_o   = rs1[rd_ptr];
    assign head_rs2_o   = rs2[rd_ptr];
    assign entry_valid_o = valid;

    always_comb begin
        for (int i = 0; i < Depth; i++) begin
            entry_ids_o[i] = ids[i];
        end
    end

endmodule

`default_nettype wire

// File: rtl/cvxif_copro_responder.sv
// CV-X-IF coprocessor responder: decodes ADD/XOR/MUL/NOP, queues accepted
// instructions and returns results in issue order once each is committed.
`default_nettype none

module cvxif_copro_responder
    import cvxif_copro_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int Depth   = 4,
    parameter int IdWidth = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               issue_valid_i,
    output logic               issue_ready_o,
    input  logic [31:0]        issue_instr_i,
    input  logic [IdWidth-1:0] issue_id_i,
    input  logic [XLEN-1:0]    issue_rs1_i,
    input  logic [XLEN-1:0]    issue_rs2_i,
    output logic               issue_accept_o,
    output logic               issue_writeback_o,
    input  logic               commit_valid_i,
    input  logic [IdWidth-1:0] commit_id_i,
    input  logic               commit_kill_i,
    output logic               result_valid_o,
    input  logic               result_ready_i,
    output logic [IdWidth-1:0] result_id_o,
    output logic [4:0]         result_rd_o,
    output logic [XLEN-1:0]    result_data_o,
    output logic               result_we_o
);

    logic [2:0]                   funct3;
    logic                         push;
    logic                         pop;
    entry_meta_t                  push_meta;
    logic [Depth-1:0]             commit_set;
    logic [Depth-1:0]             kill_set;
    logic                         head_valid;
    logic [IdWidth-1:0]           head_id;
    entry_meta_t                  head_meta;
    logic [XLEN-1:0]              head_rs1;
    logic [XLEN-1:0]              head_rs2;
    logic [Depth-1:0]             entry_valid;
    logic [Depth-1:0][IdWidth-1:0] entry_ids;
    logic [XLEN-1:0]              alu_result;
    state_e                       state;
    logic [1:0]                   mul_cnt;
    logic                         unused_instr_bits;

    assign funct3            = issue_instr_i[14:12];
    assign issue_accept_o    = (issue_instr_i[6:0] == OPCODE_COPRO) && !funct3[2];
    assign issue_writeback_o = issue_accept_o && (funct3 != OP_NOP);
    assign push              = issue_valid_i && issue_ready_o && issue_accept_o;
    assign unused_instr_bits = ^issue_instr_i[31:15];

    always_comb begin
        push_meta           = '0;
        push_meta.op        = op_e'(funct3);
        push_meta.rd        = issue_instr_i[11:7];
        push_meta.committed = 1'b0;
        push_meta.killed    = 1'b0;
    end

    // Only entries already stored can match, so a same-cycle push is untouched.
    always_comb begin
        commit_set = '0;
        kill_set   = '0;
        for (int i = 0; i < Depth; i++) begin
            if (commit_valid_i && entry_valid[i] && (entry_ids[i] == commit_id_i)) begin
                if (commit_kill_i) begin
                    kill_set[i] = 1'b1;
                end else begin
                    commit_set[i] = 1'b1;
                end
            end
        end
    end

    cvxif_copro_fifo #(
        .XLEN    (XLEN),
        .Depth   (Depth),
        .IdWidth (IdWidth)
    ) u_fifo (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .push_i        (push),
        .push_id_i     (issue_id_i),
        .push_meta_i   (push_meta),
        .push_rs1_i    (issue_rs1_i),
        .push_rs2_i    (issue_rs2_i),
        .pop_i         (pop),
        .commit_set_i  (commit_set),
        .kill_set_i    (kill_set),
        .not_full_o    (issue_ready_o),
        .head_valid_o  (head_valid),
        .head_id_o     (head_id),
        .head_meta_o   (head_meta),
        .head_rs1_o    (head_rs1),
        .head_rs2_o    (head_rs2),
        .entry_valid_o (entry_valid),
        .entry_ids_o   (entry_ids)
    );

    always_comb begin
        alu_result = head_rs1 + head_rs2;
        case (head_meta.op)
            OP_XOR:  alu_result = head_rs1 ^ head_rs2;
            OP_MUL:  alu_result = head_rs1 * head_rs2;
            default: alu_result = head_rs1 + head_rs2;
        endcase
    end

    always_comb begin
        pop = 1'b0;
        case (state)
            S_IDLE:  pop = head_valid && (head_meta.killed ||
                           (head_meta.committed && (head_meta.op == OP_NOP)));
            S_RESP:  pop = result_ready_i;
            default: pop = 1'b0;
        endcase
    end

    // Once the head leaves IDLE its flags are no longer consulted, so a late
    // kill cannot suppress a result already in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state          <= S_IDLE;
            mul_cnt        <= '0;
            result_valid_o <= 1'b0;
            result_we_o    <= 1'b0;
            result_id_o    <= '0;
            result_rd_o    <= '0;
            result_data_o  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (head_valid && !head_meta.killed && head_meta.committed) begin
                        if (head_meta.op == OP_MUL) begin
                            mul_cnt <= MUL_CNT_INIT;
                            state   <= S_EXEC;
                        end else if (head_meta.op != OP_NOP) begin
                            result_valid_o <= 1'b1;
                            result_we_o    <= 1'b1;
                            result_id_o    <= head_id;
                            result_rd_o    <= head_meta.rd;
                            result_data_o  <= alu_result;
                            state          <= S_RESP;
                        end
                    end
                end
                S_EXEC: begin
                    if (mul_cnt == 2'd0) begin
                        result_valid_o <= 1'b1;
                        result_we_o    <= 1'b1;
                        result_id_o    <= head_id;
                        result_rd_o    <= head_meta.rd;
                        result_data_o  <= alu_result;
                        state          <= S_RESP;
                    end else begin
                        mul_cnt <= mul_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    if (result_ready_i) begin
                        result_valid_o <= 1'b0;
                        result_we_o    <= 1'b0;
                        state          <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cvxif_copro_responder.sv
// Self-checking bench for cvxif_copro_responder: decode vector table plus
// scoreboarded multi-cycle sequences.
`default_nettype none

module tb_cvxif_copro_responder;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic [31:0] issue_instr_i;
    logic [3:0]  issue_id_i;
    logic [31:0] issue_rs1_i;
    logic [31:0] issue_rs2_i;
    logic        issue_accept_o;
    logic        issue_writeback_o;
    logic        commit_valid_i;
    logic [3:0]  commit_id_i;
    logic        commit_kill_i;
    logic        result_valid_o;
    logic        result_ready_i;
    logic [3:0]  result_id_o;
    logic [4:0]  result_rd_o;
    logic [31:0] result_data_o;
    logic        result_we_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    cvxif_copro_responder dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .issue_valid_i     (issue_valid_i),
        .issue_ready_o     (issue_ready_o),
        .issue_instr_i     (issue_instr_i),
        .issue_id_i        (issue_id_i),
        .issue_rs1_i       (issue_rs1_i),
        .issue_rs2_i       (issue_rs2_i),
        .issue_accept_o    (issue_accept_o),
        .issue_writeback_o (issue_writeback_o),
        .commit_valid_i    (commit_valid_i),
        .commit_id_i       (commit_id_i),
        .commit_kill_i     (commit_kill_i),
        .result_valid_o    (result_valid_o),
        .result_ready_i    (result_ready_i),
        .result_id_o       (result_id_o),
        .result_rd_o       (result_rd_o),
        .result_data_o     (result_data_o),
        .result_we_o       (result_we_o)
    );

    typedef struct {
        logic [31:0] instr;
        logic        acc;
        logic        wb;
    } dec_vec_t;

    typedef struct {
        logic [3:0]  id;
        logic [4:0]  rd;
        logic [31:0] data;
    } sb_t;

    sb_t         sb[$];
    sb_t         mon_e;
    logic [2:0]  mdl_op  [16];
    logic [4:0]  mdl_rd  [16];
    logic [31:0] mdl_a   [16];
    logic [31:0] mdl_b   [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        case (op)
            3'd1:    return a ^ b;
            3'd2:    return 32'(64'(a) * 64'(b));
            default: return a + b;
        endcase
    endfunction

    function automatic logic [31:0] mk_instr(input logic [6:0] opc, input logic [2:0] f3,
                                             input logic [4:0] rd);
        return {17'h0, f3, rd, opc};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_issue(input logic [2:0] f3, input logic [3:0] id, input logic [4:0] rd,
                            input logic [31:0] a, input logic [31:0] b, output logic taken);
        issue_valid_i = 1'b1;
        issue_instr_i = mk_instr(7'b1111011, f3, rd);
        issue_id_i    = id;
        issue_rs1_i   = a;
        issue_rs2_i   = b;
        taken         = issue_ready_o;
        if (taken) begin
            mdl_op[id] = f3;
            mdl_rd[id] = rd;
            mdl_a[id]  = a;
            mdl_b[id]  = b;
        end
        tick();
        issue_valid_i = 1'b0;
    endtask

    task automatic do_commit(input logic [3:0] id, input logic kill);
        sb_t e;
        commit_valid_i = 1'b1;
        commit_id_i    = id;
        commit_kill_i  = kill;
        if (!kill && mdl_op[id] != 3'd3) begin
            e.id   = id;
            e.rd   = mdl_rd[id];
            e.data = ref_result(mdl_op[id], mdl_a[id], mdl_b[id]);
            sb.push_back(e);
        end
        tick();
        commit_valid_i = 1'b0;
        commit_kill_i  = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && sb.size() != 0; i++) tick();
        repeat (3) tick();
        chk(name, 64'(sb.size()), 64'd0);
    endtask

    always @(negedge clk_i) begin
        if (rst_ni === 1'b1 && result_valid_o === 1'b1 && result_ready_i === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: got id %0h data %0h expected none",
                         result_id_o, result_data_o);
            end else begin
                mon_e = sb.pop_front();
                chk("res_id", 64'(result_id_o), 64'(mon_e.id));
                chk("res_rd", 64'(result_rd_o), 64'(mon_e.rd));
                chk("res_data", 64'(result_data_o), 64'(mon_e.data));
                chk("res_we", 64'(result_we_o), 64'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        dec_vec_t vec [8];
        logic     taken;

        vec[0] = '{mk_instr(7'b1111011, 3'd0, 5'd1), 1'b1, 1'b1};
        vec[1] = '{mk_instr(7'b1111011, 3'd1, 5'd2), 1'b1, 1'b1};
        vec[2] = '{mk_instr(7'b1111011, 3'd2, 5'd3), 1'b1, 1'b1};
        vec[3] = '{mk_instr(7'b1111011, 3'd3, 5'd4), 1'b1, 1'b0};
        vec[4] = '{mk_instr(7'b1111011, 3'd4, 5'd5), 1'b0, 1'b0};
        vec[5] = '{mk_instr(7'b1111011, 3'd7, 5'd6), 1'b0, 1'b0};
        vec[6] = '{mk_instr(7'b0110011, 3'd0, 5'd7), 1'b0, 1'b0};
        vec[7] = '{mk_instr(7'b1111010, 3'd1, 5'd8), 1'b0, 1'b0};

        rst_ni         = 1'b0;
        issue_valid_i  = 1'b0;
        issue_instr_i  = '0;
        issue_id_i     = '0;
        issue_rs1_i    = '0;
        issue_rs2_i    = '0;
        commit_valid_i = 1'b0;
        commit_id_i    = '0;
        commit_kill_i  = 1'b0;
        result_ready_i = 1'b1;
        repeat (3) tick();
        rst_ni = 1'b1;

        chk("rst_ready", 64'(issue_ready_o), 64'd1);
        chk("rst_valid", 64'(result_valid_o), 64'd0);
        chk("rst_we", 64'(result_we_o), 64'd0);
        chk("rst_id", 64'(result_id_o), 64'd0);
        chk("rst_rd", 64'(result_rd_o), 64'd0);
        chk("rst_data", 64'(result_data_o), 64'd0);

        for (int i = 0; i < 8; i++) begin
            issue_instr_i = vec[i].instr;
            #1;
            chk($sformatf("dec_accept[%0d]", i), 64'(issue_accept_o), 64'(vec[i].acc));
            chk($sformatf("dec_wb[%0d]", i), 64'(issue_writeback_o), 64'(vec[i].wb));
        end
        tick();

        // ADD id=2: 5+7, result one cycle after the commit edge
        do_issue(3'd0, 4'd2, 5'd10, 32'd5, 32'd7, taken);
        chk("add_taken", 64'(taken), 64'd1);
        do_commit(4'd2, 1'b0);
        chk("add_not_yet", 64'(result_valid_o), 64'd0);
        tick();
        chk("add_valid", 64'(result_valid_o), 64'd1);
        chk("add_data", 64'(result_data_o), 64'd12);
        chk("add_rd", 64'(result_rd_o), 64'd10);
        chk("add_id", 64'(result_id_o), 64'd2);
        drain("add_drain");

        // Rejected opcode leaves the queue empty: four accepted issues fill it exactly
        issue_valid_i = 1'b1;
        issue_instr_i = mk_instr(7'b0110011, 3'd0, 5'd3);
        issue_id_i    = 4'd9;
        #1;
        chk("rej_accept", 64'(issue_accept_o), 64'd0);
        chk("rej_wb", 64'(issue_writeback_o), 64'd0);
        tick();
        issue_valid_i = 1'b0;
        chk("rej_ready", 64'(issue_ready_o), 64'd1);
        for (int i = 1; i <= 4; i++) begin
            do_issue(3'd0, 4'(i), 5'(i + 16), 32'(i * 100), 32'(i), taken);
            chk($sformatf("fill_taken[%0d]", i), 64'(taken), 64'd1);
        end
        chk("full_ready", 64'(issue_ready_o), 64'd0);
        do_issue(3'd0, 4'd5, 5'd21, 32'd1, 32'd1, taken);
        chk("full_5th_taken", 64'(taken), 64'd0);
        do_commit(4'd1, 1'b0);
        for (int i = 0; i < 10 && !issue_ready_o; i++) tick();
        chk("ready_back", 64'(issue_ready_o), 64'd1);
        chk("ready_sb", 64'(sb.size()), 64'd0);
        do_commit(4'd2, 1'b0);
        do_commit(4'd3, 1'b0);
        do_commit(4'd4, 1'b0);
        drain("fill_drain");

        // MUL wraps modulo 2^32, result five cycles after commit, held under backpressure
        result_ready_i = 1'b0;
        do_issue(3'd2, 4'd5, 5'd9, 32'hFFFF_FFFF, 32'd2, taken);
        do_commit(4'd5, 1'b0);
        for (int n = 1; n <= 5; n++) begin
            tick();
            chk($sformatf("mul_lat[%0d]", n), 64'(result_valid_o), 64'(n == 5));
        end
        chk("mul_data", 64'(result_data_o), 64'hFFFF_FFFE);
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("hold_valid", 64'(result_valid_o), 64'd1);
            chk("hold_data", 64'(result_data_o), 64'hFFFF_FFFE);
            chk("hold_id", 64'(result_id_o), 64'd5);
            chk("hold_rd", 64'(result_rd_o), 64'd9);
        end
        result_ready_i = 1'b1;
        tick();
        chk("mul_released", 64'(result_valid_o), 64'd0);
        drain("mul_drain");

        // Kill of a middle entry: results only for ids 1 and 3, in order
        do_issue(3'd0, 4'd1, 5'd11, 32'd40, 32'd2, taken);
        do_issue(3'd1, 4'd2, 5'd12, 32'hF0F0_0000, 32'h0FF0_1234, taken);
        do_issue(3'd1, 4'd3, 5'd13, 32'hAAAA_5555, 32'h1234_5678, taken);
        do_commit(4'd2, 1'b1);
        do_commit(4'd1, 1'b0);
        do_commit(4'd3, 1'b0);
        drain("kill_drain");

        // Kill arriving while the MUL is executing is ignored
        do_issue(3'd2, 4'd6, 5'd14, 32'd1234, 32'd5678, taken);
        do_commit(4'd6, 1'b0);
        tick();
        do_commit(4'd6, 1'b1);
        drain("late_kill_drain");

        // Reset in the middle of a MUL leaves no stale result
        do_issue(3'd2, 4'd7, 5'd15, 32'd3, 32'd4, taken);
        do_commit(4'd7, 1'b0);
        tick();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        sb.delete();
        chk("rst_exec_valid", 64'(result_valid_o), 64'd0);
        chk("rst_exec_ready", 64'(issue_ready_o), 64'd1);
        repeat (8) tick();
        chk("rst_no_stale", 64'(result_valid_o), 64'd0);
        do_issue(3'd1, 4'd8, 5'd16, 32'h0000_FFFF, 32'h00FF_00FF, taken);
        do_commit(4'd8, 1'b0);
        drain("post_rst_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
